led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The module SHALL have parameter N_LEDS, default 10, giving the LED bar width (legal range 4..32).
REQ-002 The module SHALL have parameter FLICKER_LOOPS, default 2, giving the number of flicker passes before completion (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port step, input, 1 bit: advance request; one advance per cycle in which it is high.
REQ-006 The module SHALL have port restart, input, 1 bit: synchronous return to IDLE.
REQ-007 The module SHALL have port mode, input, 2 bits: 00 one-hot, 01 thermometer, 10 bounce, 11 treated as 00.
REQ-008 The module SHALL have port leds, output, N_LEDS bits: registered LED pattern.
REQ-009 The module SHALL have port done, output, 1 bit: registered; high while in DONE.

Function
REQ-010 The FSM SHALL have states IDLE, COUNT, FLICKER and DONE, with a position index pos (0..N_LEDS-1), a direction flag, a flicker index f (0..5) and a loop counter.
REQ-011 restart=1 SHALL force IDLE, leds=0, done=0 on the next edge, overriding step in every state.
REQ-012 In IDLE, step SHALL latch mode, set pos=0 and direction=up, and enter COUNT; leds=0 while in IDLE.
REQ-013 In COUNT, one-hot mode SHALL drive leds with only bit pos set; thermometer mode SHALL drive bits pos..0 set.
REQ-014 In COUNT for one-hot and thermometer, step SHALL increment pos; step at pos=N_LEDS-1 SHALL enter FLICKER with f=0.
REQ-015 In bounce mode, leds SHALL be one-hot; pos SHALL rise to N_LEDS-1, then fall to 0 on subsequent steps; step at pos=0 with direction=down SHALL enter FLICKER with f=0.
REQ-016 FLICKER patterns SHALL be: f=0 odd bits set; f=1 even bits set; f=2 bits with i mod 3=1; f=3 bits with i mod 3=2; f=4 bits with i mod 3=0; f=5 all bits set.
REQ-017 In FLICKER, step SHALL advance f by one for f<5.
REQ-018 At f=5, step SHALL go to f=1 and increment the loop counter if fewer than FLICKER_LOOPS passes are complete; otherwise it SHALL enter DONE.
REQ-019 In DONE, leds SHALL be all ones and done=1; step SHALL be ignored.
REQ-020 leds and done SHALL update on the same edge that samples step or restart; latency is one edge, with no combinational path from inputs to outputs.
REQ-021 A mode change after leaving IDLE SHALL have no effect until the next IDLE exit.
REQ-022 With step low, all state SHALL hold.

Reset
REQ-023 reset=0 SHALL immediately, independent of clk, force IDLE, pos=0, f=0, loop counter=0, direction=up, leds=0 and done=0.
REQ-024 Reset asserted mid-sequence SHALL discard all progress; the first step after release SHALL behave as from IDLE.

Configuration
REQ-025 When macro LED_SEQUENCER_PWM_EN is defined, a port brightness (input, 4 bits) and a free-running 4-bit counter pwm_cnt (reset to 0) SHALL be added.
REQ-026 With LED_SEQUENCER_PWM_EN defined, leds SHALL equal pattern AND (pwm_cnt < brightness OR brightness=15), registered; brightness=0 SHALL blank the LEDs.
REQ-027 Without LED_SEQUENCER_PWM_EN, the brightness port and pwm_cnt SHALL be absent and leds SHALL equal the pattern.
REQ-028 done SHALL be unaffected by PWM in both builds.

Structure
REQ-029 Package led_seq_pkg SHALL hold the state enum, the mode enum (including MODE_ONEHOT, MODE_THERM, MODE_BOUNCE) and the flicker index constants.
REQ-030 Sub-module led_pattern_gen SHALL be a purely combinational decode of {state, latched mode, pos, f} to an N_LEDS pattern; led_sequencer SHALL register its output.

Verification (N_LEDS=10, FLICKER_LOOPS=2)
REQ-031 A bench SHALL check: one-hot mode, 10 steps -> leds 0x001, 0x002, ..., 0x200; 11th step -> 0x2AA.
REQ-032 A bench SHALL check: thermometer mode, 3 steps -> 0x001, 0x003, 0x007.
REQ-033 A bench SHALL check: bounce mode, 19 steps -> leds 0x001 up to 0x200 then back to 0x001; 20th step -> 0x2AA.
REQ-034 A bench SHALL check: from f=0, steps -> 0x155, 0x092, 0x124, 0x249, 0x3FF, then 0x155 ... 0x3FF, then DONE with done=1, leds=0x3FF; further steps -> no change.
REQ-035 A bench SHALL check: reset low mid-clock at pos=5 -> leds=0 immediately; restart and step high together in COUNT -> IDLE, leds=0.
REQ-036 A bench SHALL check: PWM build, brightness=4 in DONE -> leds=0x3FF for 4 of every 16 cycles; brightness=0 -> leds=0 with done=1.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: FSM states, pattern modes and flicker phase indices.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_FLICKER = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam logic [2:0] FLK_ODD  = 3'd0;
    localparam logic [2:0] FLK_EVEN = 3'd1;
    localparam logic [2:0] FLK_MOD1 = 3'd2;
    localparam logic [2:0] FLK_MOD2 = 3'd3;
    localparam logic [2:0] FLK_MOD0 = 3'd4;
    localparam logic [2:0] FLK_ALL  = 3'd5;

endpackage

// File: rtl/led_pattern_gen.sv
// Combinational decode of sequencer state, latched mode, position and flicker phase
// into the LED bar pattern.
module led_pattern_gen
    import led_seq_pkg::*;
#(
    parameter int N_LEDS = 10,
    parameter int POS_W  = 4
) (
    input  state_t             state,
    input  mode_t              mode,
    input  logic [POS_W-1:0]   pos,
    input  logic [2:0]         flk,
    output logic [N_LEDS-1:0]  pattern
);

    // Reserved mode 11 falls through to one-hot, as does bounce.
    always_comb begin
        pattern = '0;
        unique case (state)
            ST_COUNT: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    if (mode == MODE_THERM)
                        pattern[i] = (POS_W'(i) <= pos);
                    else
                        pattern[i] = (POS_W'(i) == pos);
                end
            end
            ST_FLICKER: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    case (flk)
                        FLK_ODD:  pattern[i] = ((i % 2) == 1);
                        FLK_EVEN: pattern[i] = ((i % 2) == 0);
                        FLK_MOD1: pattern[i] = ((i % 3) == 1);
                        FLK_MOD2: pattern[i] = ((i % 3) == 2);
                        FLK_MOD0: pattern[i] = ((i % 3) == 0);
                        default:  pattern[i] = 1'b1;
                    endcase
                end
            end
            ST_DONE:  pattern = '1;
            default:  pattern = '0;
        endcase
    end

endmodule

// File: rtl/led_sequencer.sv
// Step-driven LED bar sequencer: count/bounce run, flicker loops, then done.
// Optional PWM dimming via the brightness port when LED_SEQUENCER_PWM_EN is defined.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS        = 10,
    parameter int FLICKER_LOOPS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              restart,
    input  logic [1:0]        mode,
`ifdef LED_SEQUENCER_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic [N_LEDS-1:0] leds,
    output logic              done
);

    localparam int POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

    state_t             state, state_n;
    mode_t              mode_q, mode_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic               dir_down, dir_down_n;
    logic [2:0]         flk, flk_n;
    logic [3:0]         loop_cnt, loop_cnt_n;
    logic [N_LEDS-1:0]  pattern;

    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        pos_n      = pos;
        dir_down_n = dir_down;
        flk_n      = flk;
        loop_cnt_n = loop_cnt;
        if (restart) begin
            state_n    = ST_IDLE;
            pos_n      = '0;
            dir_down_n = 1'b0;
            flk_n      = FLK_ODD;
            loop_cnt_n = '0;
        end else if (step) begin
            unique case (state)
                ST_IDLE: begin
                    mode_n     = mode_t'(mode);
                    pos_n      = '0;
                    dir_down_n = 1'b0;
                    state_n    = ST_COUNT;
                end
                ST_COUNT: begin
                    if (mode_q == MODE_BOUNCE) begin
                        if (!dir_down) begin
                            if (pos == POS_LAST) begin
                                dir_down_n = 1'b1;
                                pos_n      = pos - POS_W'(1);
                            end else begin
                                pos_n = pos + POS_W'(1);
                            end
                        end else if (pos == '0) begin
                            state_n    = ST_FLICKER;
                            flk_n      = FLK_ODD;
                            loop_cnt_n = '0;
                        end else begin
                            pos_n = pos - POS_W'(1);
                        end
                    end else if (pos == POS_LAST) begin
                        state_n    = ST_FLICKER;
                        flk_n      = FLK_ODD;
                        loop_cnt_n = '0;
                    end else begin
                        pos_n = pos + POS_W'(1);
                    end
                end
                ST_FLICKER: begin
                    // Repeat passes restart at the even phase, not the odd one.
                    if (flk != FLK_ALL) begin
                        flk_n = flk + 3'd1;
                    end else if ((int'(loop_cnt) + 1) < FLICKER_LOOPS) begin
                        flk_n      = FLK_EVEN;
                        loop_cnt_n = loop_cnt + 4'd1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    // Decode the next state so the registered LEDs change on the same edge as the FSM.
    led_pattern_gen #(
        .N_LEDS (N_LEDS),
        .POS_W  (POS_W)
    ) u_pattern (
        .state   (state_n),
        .mode    (mode_n),
        .pos     (pos_n),
        .flk     (flk_n),
        .pattern (pattern)
    );

`ifdef LED_SEQUENCER_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (pwm_cnt < brightness) || (brightness == 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_ONEHOT;
            pos      <= '0;
            dir_down <= 1'b0;
            flk      <= FLK_ODD;
            loop_cnt <= '0;
            leds     <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            pos      <= pos_n;
            dir_down <= dir_down_n;
            flk      <= flk_n;
            loop_cnt <= loop_cnt_n;
`ifdef LED_SEQUENCER_PWM_EN
            leds     <= pattern & {N_LEDS{pwm_on}};
`else
            leds     <= pattern;
`endif
            done     <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a list-based reference model predicts each edge,
// a monitor compares. Define LED_SEQUENCER_PWM_EN to also cover the brightness port.
module tb_led_sequencer;

    localparam int N  = 10;
    localparam int FL = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         step = 1'b0;
    logic         restart = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] leds;
    logic         done;
`ifdef LED_SEQUENCER_PWM_EN
    logic [3:0]   brightness = 4'hF;
    int           pwmModel = 0;
`endif

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] seqPat[$];
    int          seqIdx = 0;
    bit          active = 1'b0;

    logic [31:0] expLeds[$];
    logic        expDone[$];
    string       expTag[$];

    led_sequencer #(
        .N_LEDS        (N),
        .FLICKER_LOOPS (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .restart    (restart),
        .mode       (mode),
`ifdef LED_SEQUENCER_PWM_EN
        .brightness (brightness),
`endif
        .leds       (leds),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] flickerPattern(input int f);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            case (f)
                0:       p[i] = ((i % 2) == 1);
                1:       p[i] = ((i % 2) == 0);
                2:       p[i] = ((i % 3) == 1);
                3:       p[i] = ((i % 3) == 2);
                4:       p[i] = ((i % 3) == 0);
                default: p[i] = 1'b1;
            endcase
        end
        return p;
    endfunction

    function automatic logic [31:0] onePattern(input int p);
        return 32'd1 << p;
    endfunction

    function automatic logic [31:0] thermPattern(input int p);
        logic [63:0] t;
        t = (64'd1 << (p + 1)) - 64'd1;
        return t[31:0];
    endfunction

    // The full run a sequence will walk through, from its first step to DONE.
    task automatic buildSequence(input logic [1:0] md);
        logic [63:0] allOnes;
        seqPat.delete();
        if (md == 2'b01) begin
            for (int p = 0; p < N; p++) seqPat.push_back(thermPattern(p));
        end else if (md == 2'b10) begin
            for (int p = 0; p < N; p++) seqPat.push_back(onePattern(p));
            for (int p = N - 2; p >= 0; p--) seqPat.push_back(onePattern(p));
        end else begin
            for (int p = 0; p < N; p++) seqPat.push_back(onePattern(p));
        end
        for (int f = 0; f < 6; f++) seqPat.push_back(flickerPattern(f));
        for (int l = 1; l < FL; l++)
            for (int f = 1; f < 6; f++) seqPat.push_back(flickerPattern(f));
        allOnes = (64'd1 << N) - 64'd1;
        seqPat.push_back(allOnes[31:0]);
    endtask

    task automatic applyStimulus(input bit st, input bit rs, input logic [1:0] md, input bit rn,
                                 input string tag);
        logic [31:0] pat;
        bit          d;
        bit          gate;
        @(negedge clk);
        step    = st;
        restart = rs;
        mode    = md;
        reset   = rn;
        if (!rn) begin
            active = 1'b0;
        end else if (rs) begin
            active = 1'b0;
        end else if (st) begin
            if (!active) begin
                buildSequence(md);
                seqIdx = 0;
                active = 1'b1;
            end else if (seqIdx < seqPat.size() - 1) begin
                seqIdx++;
            end
        end
        pat = active ? seqPat[seqIdx] : 32'd0;
        d   = active && (seqIdx == seqPat.size() - 1);
`ifdef LED_SEQUENCER_PWM_EN
        if (!rn) begin
            pwmModel = 0;
            gate = 1'b0;
        end else begin
            gate = (pwmModel < int'(brightness)) || (brightness == 4'hF);
            pwmModel = (pwmModel + 1) % 16;
        end
`else
        gate = 1'b1;
`endif
        expLeds.push_back(gate ? pat : 32'd0);
        expDone.push_back(d);
        expTag.push_back(tag);
    endtask

    initial begin : monitor
        logic [31:0] el;
        logic        ed;
        string       et;
        forever begin
            @(posedge clk);
            #1;
            if (expLeds.size() > 0) begin
                el = expLeds.pop_front();
                ed = expDone.pop_front();
                et = expTag.pop_front();
                checkOutput({et, "_leds"}, 32'(leds), el);
                checkOutput({et, "_done"}, 32'(done), 32'(ed));
            end
        end
    end

    initial begin : driver
        int onCount;
        applyStimulus(0, 0, 2'b00, 0, "reset");
        applyStimulus(1, 0, 2'b00, 0, "reset_step");
        applyStimulus(0, 0, 2'b00, 1, "idle_hold");

        for (int i = 0; i < 11; i++) applyStimulus(1, 0, 2'b00, 1, "onehot");
        applyStimulus(0, 1, 2'b00, 1, "restart");

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2'b01, 1, "therm");
        applyStimulus(1, 1, 2'b01, 1, "restart_over_step");
        applyStimulus(0, 0, 2'b01, 1, "idle_after_restart");

        applyStimulus(1, 0, 2'b10, 1, "bounce");
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1, 0, 2'($urandom_range(0, 3)), 1, "bounce_mode_ignored");
            if (i % 7 == 0) applyStimulus(0, 0, 2'b00, 1, "bounce_hold");
        end
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 0, 2'b00, 1, "flicker_done");
            if (i % 4 == 1) applyStimulus(0, 0, 2'b00, 1, "flicker_hold");
        end

        applyStimulus(0, 1, 2'b00, 1, "restart");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 2'b00, 1, "to_pos5");
        applyStimulus(0, 0, 2'b00, 0, "reset_mid");
        #1;
        checkOutput("async_reset_leds", 32'(leds), 32'd0);
        checkOutput("async_reset_done", 32'(done), 32'd0);
        applyStimulus(1, 0, 2'b00, 0, "reset_held");
        applyStimulus(1, 0, 2'b01, 1, "after_reset");
        applyStimulus(1, 0, 2'b01, 1, "after_reset");

`ifdef LED_SEQUENCER_PWM_EN
        applyStimulus(0, 1, 2'b00, 1, "restart");
        for (int i = 0; i < 22; i++) applyStimulus(1, 0, 2'b00, 1, "pwm_to_done");
        brightness = 4'd4;
        applyStimulus(0, 0, 2'b00, 1, "pwm_settle");
        onCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 2'b00, 1, "pwm_b4");
            @(posedge clk);
            #2;
            if (leds == '1) onCount++;
        end
        checkOutput("pwm_b4_on_cycles", 32'(onCount), 32'd4);
        brightness = 4'd0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 2'b00, 1, "pwm_b0");
        @(posedge clk);
        #2;
        checkOutput("pwm_b0_leds", 32'(leds), 32'd0);
        checkOutput("pwm_b0_done", 32'(done), 32'd1);
        brightness = 4'hF;
`else
        onCount = 0;
`endif

        for (int i = 0; i < 1500; i++) begin
            bit st;
            bit rs;
            bit rn;
            st = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 49) == 0);
            rn = ($urandom_range(0, 299) != 0);
`ifdef LED_SEQUENCER_PWM_EN
            if ($urandom_range(0, 63) == 0) brightness = 4'($urandom_range(0, 15));
`endif
            applyStimulus(st, rs, 2'($urandom_range(0, 3)), rn, "random");
        end

        for (int i = 0; i < 10 && expLeds.size() > 0; i++) @(posedge clk);
        #3;
        if (expLeds.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expLeds.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
